// File: rtl/mca_event_source_pkg.sv
// Shared constants, FSM state type and LFSR step function for the MCA event source.
package mca_pkg;

  localparam int NCH = 1024;
  localparam int CW  = 10;
  localparam int SW  = 32;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    DRAW,
    RD,
    CMP,
    OUT
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/mca_event_source_if.sv
// Valid/ready event stream carrying a channel index from the source to the histogram block.
interface mca_event_source_if #(
  parameter int CW = mca_pkg::CW
) ();

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_chan;

  modport master (
    output evt_valid,
    output evt_chan,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_chan,
    output evt_ready
  );

endinterface

// File: rtl/mca_event_source_lfsr32.sv
// 32-bit Galois LFSR that steps only when 'advance' is high; a zero seed is forced to 1.
module mca_lfsr32
  import mca_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1ACE_B00C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] value
);

  localparam logic [31:0] START = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= START;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/mca_event_source.sv
// Spectrum-shaped event generator: CDF load, LFSR draw with rejection, binary search over the CDF.
// Optional `define MCA_EVT_CNT_EN adds a saturating count of accepted events on port evt_count.
module mca_event_source
  import mca_pkg::*;
#(
  parameter int          NCH  = mca_pkg::NCH,
  parameter int          CW   = mca_pkg::CW,
  parameter int          SW   = mca_pkg::SW,
  parameter logic [31:0] SEED = 32'h1ACE_B00C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [15:0]         load_data,
  output logic                load_done,
  output logic                empty,
  output logic [SW-1:0]       total,
  input  logic                enable,
  mca_event_source_if.master  evt
`ifdef MCA_EVT_CNT_EN
  ,
  output logic [31:0]         evt_count
`endif
);

  state_t        state, state_next;
  logic [CW:0]   addr;
  logic [SW-1:0] acc, total_q, mask, mask_calc, r, r_next, rdata, wdata;
  logic [CW-1:0] lo, hi, mid, lo_next, hi_next, chan, ram_addr;
  logic          load_done_q, empty_q, cmp_lt, search_more, ram_we, lfsr_adv, load_accept;
  logic [31:0]   lfsr_val;
  logic [SW-1:0] cdf [NCH];

  mca_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign wdata       = acc + SW'(load_data);
  assign r_next      = SW'(lfsr_val) & mask;
  assign mid         = CW'(({1'b0, lo} + {1'b0, hi}) >> 1);
  assign cmp_lt      = r < rdata;
  assign lo_next     = cmp_lt ? lo : mid + CW'(1);
  assign hi_next     = cmp_lt ? mid : hi;
  assign search_more = lo_next < hi_next;
  assign ram_addr    = (state == LOAD) ? addr[CW-1:0] : mid;
  assign load_accept = load_start && ((state == IDLE) || (state == READY));

  // Smear the bits of total-1 downwards to get the smallest all-ones mask covering it
  always_comb begin
    mask_calc = acc - SW'(1);
    for (int s = 1; s < SW; s = s * 2) begin
      mask_calc = mask_calc | (mask_calc >> s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (load_start) state_next = LOAD;
      LOAD:  if (addr[CW]) state_next = READY;
      READY: begin
        if (load_start) begin
          state_next = LOAD;
        end else if (enable && !empty_q) begin
          state_next = DRAW;
        end
      end
      DRAW:  if (r_next < total_q) state_next = RD;
      RD:    state_next = CMP;
      CMP:   state_next = search_more ? RD : OUT;
      OUT:   if (evt.evt_ready) state_next = enable ? DRAW : READY;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    evt.evt_valid = 1'b0;
    ram_we        = 1'b0;
    lfsr_adv      = 1'b0;
    unique case (state)
      LOAD:    ram_we        = load_valid && !addr[CW];
      DRAW:    lfsr_adv      = 1'b1;
      OUT:     evt.evt_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-port CDF store; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      cdf[ram_addr] <= wdata;
    end
    rdata <= cdf[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      acc         <= '0;
      total_q     <= '0;
      load_done_q <= 1'b0;
      empty_q     <= 1'b0;
      mask        <= '0;
      r           <= '0;
      lo          <= '0;
      hi          <= '0;
      chan        <= '0;
    end else begin
      unique case (state)
        IDLE, READY: begin
          if (load_start) begin
            addr        <= '0;
            acc         <= '0;
            total_q     <= '0;
            load_done_q <= 1'b0;
            empty_q     <= 1'b0;
          end
        end
        LOAD: begin
          if (addr[CW]) begin
            load_done_q <= 1'b1;
            total_q     <= acc;
            empty_q     <= (acc == '0);
            mask        <= mask_calc;
          end else if (load_valid) begin
            acc  <= wdata;
            addr <= addr + (CW+1)'(1);
          end
        end
        DRAW: begin
          r  <= r_next;
          lo <= '0;
          hi <= '1;
        end
        CMP: begin
          lo <= lo_next;
          hi <= hi_next;
          if (!search_more) begin
            chan <= lo_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_done    = load_done_q;
  assign empty        = empty_q;
  assign total        = total_q;
  assign evt.evt_chan = chan;

`ifdef MCA_EVT_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || load_accept) begin
      count_q <= '0;
    end else if (evt.evt_valid && evt.evt_ready && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign evt_count = count_q;
`endif

endmodule

// File: tb/tb_mca_event_source.sv
// Scoreboard bench for mca_event_source: a reference CDF/LFSR model queues expected channels, a monitor checks them.
module tb_mca_event_source;

  localparam int          NCH  = 1024;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst, load_start, load_valid, load_done, empty, enable;
  logic [15:0] load_data;
  logic [31:0] total;
`ifdef MCA_EVT_CNT_EN
  logic [31:0] evt_count;
`endif

  mca_event_source_if evt_if ();

  mca_event_source dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_done  (load_done),
    .empty      (empty),
    .total      (total),
    .enable     (enable),
    .evt        (evt_if)
`ifdef MCA_EVT_CNT_EN
    ,
    .evt_count  (evt_count)
`endif
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          hs_count   = 0;
  int          exp_q[$];
  int          hist[NCH];
  int          counts[NCH];
  longint      cdf_model[NCH];
  longint      total_model;
  logic [31:0] lfsr_model;

  task automatic check_output(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every accepted event is checked against the oldest predicted channel
  always @(negedge clk) begin
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      hs_count++;
      hist[evt_if.evt_chan]++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_event: got chan %0d, expected none", evt_if.evt_chan);
      end else begin
        check_output("evt_chan", longint'(evt_if.evt_chan), longint'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] model_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic push_expected(input int n);
    longint m;
    longint r;
    int     j;
    m = 0;
    while (m < total_model - 1) m = (m << 1) | 1;
    repeat (n) begin
      do begin
        r = longint'(lfsr_model) & m;
        lfsr_model = model_step(lfsr_model);
      end while (r >= total_model);
      j = 0;
      while (r >= cdf_model[j]) j++;
      exp_q.push_back(j);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    enable           = 1'b0;
    evt_if.evt_ready = 1'b0;
    load_start       = 1'b0;
    load_valid       = 1'b0;
    load_data        = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst        = 1'b0;
    lfsr_model = SEED;
    exp_q.delete();
  endtask

  task automatic fill_counts(input int value);
    for (int i = 0; i < NCH; i++) counts[i] = value;
  endtask

  task automatic load_spectrum(input bit poke_start, input string tag);
    total_model = 0;
    for (int i = 0; i < NCH; i++) begin
      total_model += counts[i];
      cdf_model[i] = total_model;
    end
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      load_data  = 16'(counts[i]);
      load_start = poke_start && (i == NCH / 2);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    check_output({tag, "_done_early"}, longint'(load_done), 0);
    @(posedge clk); #1;
    check_output({tag, "_done"}, longint'(load_done), 1);
    check_output({tag, "_total"}, longint'(total), total_model);
    check_output({tag, "_empty"}, longint'(empty), (total_model == 0) ? 1 : 0);
  endtask

  task automatic apply_stimulus(input int n, input string tag);
    int start;
    int budget;
    start            = hs_count;
    budget           = n * 60 + 200;
    enable           = 1'b1;
    evt_if.evt_ready = 1'b1;
    while ((hs_count - start) < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    evt_if.evt_ready = 1'b0;
    enable           = 1'b0;
    check_output({tag, "_accepted"}, longint'(hs_count - start), longint'(n));
  endtask

  initial begin
    int start;
    int nvalid;

    do_reset();
    check_output("rst_evt_valid", longint'(evt_if.evt_valid), 0);
    check_output("rst_evt_chan", longint'(evt_if.evt_chan), 0);
    check_output("rst_load_done", longint'(load_done), 0);
    check_output("rst_empty", longint'(empty), 0);
    check_output("rst_total", longint'(total), 0);

    $display("[TB] single channel spectrum");
    fill_counts(0);
    counts[5] = 7;
    load_spectrum(1'b0, "t1");
    push_expected(100);
    apply_stimulus(100, "t1");
    check_output("t1_queue_left", longint'(exp_q.size()), 0);
`ifdef MCA_EVT_CNT_EN
    check_output("t1_evt_count", longint'(evt_count), 100);
`endif

    $display("[TB] two end channels");
    do_reset();
    fill_counts(0);
    counts[0]    = 1;
    counts[1023] = 1;
    load_spectrum(1'b0, "t2");
    for (int i = 0; i < NCH; i++) hist[i] = 0;
    push_expected(2000);
    apply_stimulus(2000, "t2");
    check_output("t2_only_ends", longint'(hist[0] + hist[1023]), 2000);
    check_output("t2_ch0_in_range", longint'(hist[0] >= 900 && hist[0] <= 1100), 1);
    check_output("t2_ch1023_in_range", longint'(hist[1023] >= 900 && hist[1023] <= 1100), 1);

    $display("[TB] uniform spectrum, latency and backpressure");
    do_reset();
    fill_counts(1);
    load_spectrum(1'b0, "t3");
    push_expected(1024);
    enable = 1'b1;
    repeat (21) begin
      @(posedge clk); #1;
    end
    check_output("t3_valid_before_22", longint'(evt_if.evt_valid), 0);
    @(posedge clk); #1;
    check_output("t3_valid_at_22", longint'(evt_if.evt_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("t4_hold_valid", longint'(evt_if.evt_valid), 1);
      check_output("t4_hold_chan", longint'(evt_if.evt_chan), longint'(exp_q[0]));
    end
    start = hs_count;
    evt_if.evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_if.evt_ready = 1'b0;
    check_output("t4_one_taken", longint'(hs_count - start), 1);
    check_output("t4_valid_dropped", longint'(evt_if.evt_valid), 0);
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_output("t4_still_one", longint'(hs_count - start), 1);
    apply_stimulus(1023, "t3");
    check_output("t3_queue_left", longint'(exp_q.size()), 0);

    $display("[TB] all-zero spectrum");
    do_reset();
    fill_counts(0);
    load_spectrum(1'b1, "t5");
    enable           = 1'b1;
    evt_if.evt_ready = 1'b1;
    nvalid           = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (evt_if.evt_valid) nvalid++;
    end
    enable           = 1'b0;
    evt_if.evt_ready = 1'b0;
    check_output("t5_valid_cycles", longint'(nvalid), 0);

    $display("[TB] reset during search");
    do_reset();
    fill_counts(1);
    load_spectrum(1'b0, "t6a");
    enable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("t6_evt_valid", longint'(evt_if.evt_valid), 0);
    check_output("t6_load_done", longint'(load_done), 0);
    check_output("t6_total", longint'(total), 0);
    check_output("t6_evt_chan", longint'(evt_if.evt_chan), 0);
    rst        = 1'b0;
    enable     = 1'b0;
    lfsr_model = SEED;
    exp_q.delete();
    load_spectrum(1'b0, "t6b");
    push_expected(5);
    apply_stimulus(5, "t6");
    check_output("t6_queue_left", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
